// File: rtl/mac_inverse_divider_pkg.sv
// Shared constants and state type for the multiply-add inverse divider.
package mac_inverse_divider_pkg;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned OUT_WIDTH = 16;
    localparam int unsigned CNT_W     = $clog2(OUT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/mac_inverse_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor when it fits.
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] pr,
    input  logic             data_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] pr_next,
    output logic             q_bit
);

    logic [WIDTH:0] cand;

    // With a nonzero divisor the result is always < divisor, so WIDTH bits suffice;
    // a zero divisor just shifts the dividend through.
    always_comb begin
        cand    = {pr, data_bit};
        q_bit   = (cand >= {1'b0, divisor});
        pr_next = q_bit ? WIDTH'(cand - {1'b0, divisor}) : WIDTH'(cand);
    end

endmodule

// File: rtl/mac_inverse_divider.sv
// Sequential restoring divider recovering A and C from A*B + C, one quotient bit per clock.
// Optional macro DIV_ZERO_DETECT_EN: zero divisor short-circuits to DONE and raises err.
module mac_inverse_divider #(
    parameter int unsigned WIDTH     = mac_inverse_divider_pkg::WIDTH,
    parameter int unsigned OUT_WIDTH = mac_inverse_divider_pkg::OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [OUT_WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [OUT_WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 err
);

    import mac_inverse_divider_pkg::*;

    localparam int unsigned CNT_BITS = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

    div_state_t            state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]  work_q, work_d;
    logic [WIDTH-1:0]      pr_q, pr_d;
    logic [WIDTH-1:0]      dvs_q, dvs_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [WIDTH-1:0]      step_pr;
    logic                  step_q;

    // work_q holds the unconsumed dividend bits on top and collects quotient bits at the bottom
    div_step #(.WIDTH(WIDTH)) u_step (
        .pr       (pr_q),
        .data_bit (work_q[OUT_WIDTH-1]),
        .divisor  (dvs_q),
        .pr_next  (step_pr),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            pr_q    <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            pr_q    <= pr_d;
            dvs_q   <= dvs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        pr_d    = pr_q;
        dvs_d   = dvs_q;
`ifdef DIV_ZERO_DETECT_EN
        err_d   = err_q;
`else
        err_d   = 1'b0;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    work_d  = dividend;
                    dvs_d   = divisor;
                    pr_d    = '0;
                    cnt_d   = CNT_BITS'(OUT_WIDTH - 1);
                    err_d   = 1'b0;
                    state_d = RUN;
`ifdef DIV_ZERO_DETECT_EN
                    if (divisor == '0) begin
                        work_d  = '1;
                        pr_d    = dividend[WIDTH-1:0];
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                work_d = {work_q[OUT_WIDTH-2:0], step_q};
                pr_d   = step_pr;
                cnt_d  = cnt_q - CNT_BITS'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = work_q;
    assign remainder = pr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mac_inverse_divider.sv
// Directed vector bench for mac_inverse_divider (default 8/16 widths).
module tb_mac_inverse_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef DIV_ZERO_DETECT_EN
    localparam logic ZERO_ERR = 1'b1;
    localparam int   ZERO_LAT = 0;
`else
    localparam logic ZERO_ERR = 1'b0;
    localparam int   ZERO_LAT = 16;
`endif

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [15:0] q;
        logic [7:0]  r;
        logic        e;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    mac_inverse_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Present a request on one edge, then scramble operands (the DUT must have captured them).
    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 8'h3C;
    endtask

    // Called 1ns after the accepting edge; lat = edges after it until done is seen.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_n++;
        end
    endtask

    initial begin
        int lat, busy_n, done_seen;

        vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0,     16};
        vecs[1] = '{16'd305,   8'd12,  16'd25,    8'd5,   1'b0,     16};
        vecs[2] = '{16'hFFFF,  8'd1,   16'hFFFF,  8'd0,   1'b0,     16};
        vecs[3] = '{16'h0005,  8'hFF,  16'd0,     8'd5,   1'b0,     16};
        vecs[4] = '{16'd100,   8'd0,   16'hFFFF,  8'h64,  ZERO_ERR, ZERO_LAT};
        vecs[5] = '{16'hFFFF,  8'hFF,  16'd257,   8'd0,   1'b0,     16};
        vecs[6] = '{16'd12345, 8'd100, 16'd123,   8'd45,  1'b0,     16};

        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #13;
        check("reset_outputs", {15'd0, busy, done, err, quotient, remainder}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].dvd, vecs[i].dvs);
            wait_done(lat, busy_n);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_cycles", i), busy_n, vecs[i].lat);
            check($sformatf("v%0d_busy_in_done", i), busy, 1'b0);
            check($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
            check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
            check($sformatf("v%0d_err", i), err, vecs[i].e);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse_end", i), done, 1'b0);
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("v%0d_hold", i), {err, quotient, remainder}, {vecs[i].e, vecs[i].q, vecs[i].r});
        end

        // start pulsed mid-run must not disturb the division in flight
        start_op(16'd1000, 8'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 16'd50; divisor = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, busy_n);
        check("ignore_latency", lat, 11);
        check("ignore_quotient", quotient, 16'd142);
        check("ignore_remainder", remainder, 8'd6);
        @(posedge clk); #1;
        check("ignore_no_restart", {busy, done}, 2'b00);

        // start held through DONE: second request accepted straight from DONE
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
        @(posedge clk); #1;
        dividend = 16'd50; divisor = 8'd5;
        wait_done(lat, busy_n);
        check("b2b_first_latency", lat, 16);
        check("b2b_first_quotient", quotient, 16'd142);
        check("b2b_first_remainder", remainder, 8'd6);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_restart", {busy, done}, 2'b10);
        wait_done(lat, busy_n);
        check("b2b_second_latency", lat, 16);
        check("b2b_second_quotient", quotient, 16'd10);
        check("b2b_second_remainder", remainder, 8'd0);

        // asynchronous reset in the middle of a division
        start_op(16'd1000, 8'd7);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {15'd0, busy, done, err, quotient, remainder}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("midreset_no_done", done_seen, 0);
        start_op(16'd305, 8'd12);
        wait_done(lat, busy_n);
        check("postreset_latency", lat, 16);
        check("postreset_quotient", quotient, 16'd25);
        check("postreset_remainder", remainder, 8'd5);
        check("postreset_err", err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
